cam_capture_dvp: RTL and testbench

Parametrised DVP camera capture block for the OV7670-class sensor path. It runs in the `pclk` domain after SCCB configuration completes. It locks to frame boundaries and packs 1 or 2 bytes per pixel, emitting single-cycle-valid pixels with x/y coordinates and a linear framebuffer write address. It also reports frame start, frame done and frame-geometry errors to the downstream frame writer.

---
 rtl/cam_pkg.sv | 13 +
 rtl/cam_byte_packer.sv | 41 ++++
 rtl/cam_capture_dvp.sv | 169 ++++++++++++++++
 tb/tb_cam_capture_dvp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and default geometry for the DVP capture path.
package cam_pkg;
    typedef enum logic [2:0] {
        ST_WAIT_CFG,
        ST_SYNC,
        ST_VBLANK,
        ST_FRAME,
        ST_LINE
    } cam_cap_state_t;
    localparam int CAM_H_ACTIVE  = 640;
    localparam int CAM_V_ACTIVE  = 480;
    localparam bit CAM_MSB_FIRST = 1'b1;
endpackage

// File: rtl/cam_byte_packer.sv
// cam_byte_packer: tracks the byte phase within a line and assembles 1- or 2-byte pixels.
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         byte_en_i,
    input  logic [7:0]                   data_i,
    output logic                         pix_done_o,
    output logic [8*BYTES_PER_PIXEL-1:0] pix_data_o,
    output logic                         odd_o
);
    logic       phase_q, phase_d, phase_eff;
    logic [7:0] hold_q, hold_d;
    logic [15:0] pair;

    // A line-entry byte is always the first byte of a pixel, whatever the old phase was.
    always_comb begin
        phase_eff  = clear_i ? 1'b0 : phase_q;
        pix_done_o = byte_en_i && (BYTES_PER_PIXEL == 1 || phase_eff);
        phase_d    = byte_en_i ? (BYTES_PER_PIXEL == 2 && !phase_eff) : phase_eff;
        hold_d     = (byte_en_i && !phase_eff) ? data_i : hold_q;
        pair       = CAM_MSB_FIRST ? {hold_q, data_i} : {data_i, hold_q};
    end

    assign pix_data_o = pair[8*BYTES_PER_PIXEL-1:0];
    assign odd_o      = phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end
endmodule

// File: rtl/cam_capture_dvp.sv
// cam_capture_dvp: frame-locked DVP capture producing pixels, coordinates and a linear write address.
module cam_capture_dvp
    import cam_pkg::*;
#(
    parameter int H_ACTIVE        = CAM_H_ACTIVE,
    parameter int V_ACTIVE        = CAM_V_ACTIVE,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int XW              = $clog2(H_ACTIVE),
    parameter int YW              = $clog2(V_ACTIVE),
    parameter int AW              = $clog2(H_ACTIVE*V_ACTIVE)
) (
    input  logic                         pclk,
    input  logic                         reset_n,
    input  logic                         config_done,
    input  logic                         vsync,
    input  logic                         href,
    input  logic [7:0]                   cam_data,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data,
    output logic                         pixel_valid,
    output logic [XW-1:0]                x_coord,
    output logic [YW-1:0]                y_coord,
    output logic [AW-1:0]                wr_addr,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic                         frame_err
);
    // One extra bit so the counters can hold H_ACTIVE / V_ACTIVE / H*V exactly when saturated.
    localparam int CW = XW + 1;
    localparam int LW = YW + 1;
    localparam int BW = AW + 1;
    localparam int PW = 8*BYTES_PER_PIXEL;

    if (BYTES_PER_PIXEL != 1 && BYTES_PER_PIXEL != 2) begin : g_bpp_err
        $error("BYTES_PER_PIXEL must be 1 or 2");
    end

    cam_cap_state_t state_q, state_d;
    logic [CW-1:0]  x_q, x_d;
    logic [LW-1:0]  y_q, y_d;
    logic [BW-1:0]  addr_q, addr_d;
    logic           err_q, err_d;
    logic [PW-1:0]  pix_q, pix_d, pack_data;
    logic [XW-1:0]  xc_q, xc_d;
    logic [YW-1:0]  yc_q, yc_d;
    logic [AW-1:0]  wa_q, wa_d;
    logic           pv_q, pv_d, fs_q, fs_d, fd_q, fd_d, fe_q, fe_d;
    logic           capture, line_clr, line_end, pix_done, odd;

    assign capture  = config_done && href && !vsync && (state_q == ST_FRAME || state_q == ST_LINE);
    assign line_clr = capture && state_q == ST_FRAME;

    cam_byte_packer #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_packer (
        .clk       (pclk),
        .rst_n     (reset_n),
        .clear_i   (line_clr),
        .byte_en_i (capture),
        .data_i    (cam_data),
        .pix_done_o(pix_done),
        .pix_data_o(pack_data),
        .odd_o     (odd)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        err_d    = err_q;
        line_end = 1'b0;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        fe_d     = 1'b0;
        pv_d     = 1'b0;
        pix_d    = pix_q;
        xc_d     = xc_q;
        yc_d     = yc_q;
        wa_d     = wa_q;
        if (!config_done) begin
            state_d = ST_WAIT_CFG;
        end else begin
            case (state_q)
                ST_WAIT_CFG: state_d = ST_SYNC;
                ST_SYNC:     state_d = vsync ? ST_VBLANK : ST_SYNC;
                ST_VBLANK: begin
                    if (!vsync) begin
                        state_d = ST_FRAME;
                        fs_d    = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_FRAME: state_d = vsync ? ST_VBLANK : href ? ST_LINE : ST_FRAME;
                ST_LINE: begin
                    state_d  = vsync ? ST_VBLANK : href ? ST_LINE : ST_FRAME;
                    line_end = vsync || !href;
                end
                default: state_d = ST_WAIT_CFG;
            endcase
        end
        // Short lines jump the address to the next row start by adding the missing remainder.
        if (line_end) begin
            y_d   = (y_q == LW'(V_ACTIVE)) ? y_q : y_q + 1'b1;
            x_d   = '0;
            err_d = err_q || x_q != CW'(H_ACTIVE) || odd;
            if (x_q < CW'(H_ACTIVE) && y_q < LW'(V_ACTIVE))
                addr_d = addr_q + BW'(H_ACTIVE) - BW'(x_q);
        end
        if (pix_done) begin
            if (x_q < CW'(H_ACTIVE) && y_q < LW'(V_ACTIVE)) begin
                pv_d   = 1'b1;
                pix_d  = pack_data;
                xc_d   = x_q[XW-1:0];
                yc_d   = y_q[YW-1:0];
                wa_d   = addr_q[AW-1:0];
                x_d    = x_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (config_done && vsync && (state_q == ST_FRAME || state_q == ST_LINE)) begin
            fd_d = 1'b1;
            fe_d = err_d || y_d != LW'(V_ACTIVE);
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_CFG;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            pix_q   <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            wa_q    <= '0;
            pv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            pix_q   <= pix_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            wa_q    <= wa_d;
            pv_q    <= pv_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            fe_q    <= fe_d;
        end
    end

    assign pixel_data  = pix_q;
    assign pixel_valid = pv_q;
    assign x_coord     = xc_q;
    assign y_coord     = yc_q;
    assign wr_addr     = wa_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign frame_err   = fe_q;
endmodule

// File: tb/tb_cam_capture_dvp.sv
// tb_cam_capture_dvp: table-driven frames with a pixel/frame scoreboard for 2- and 1-byte-per-pixel builds.
module tb_cam_capture_dvp;
    localparam int H = 4;
    localparam int V = 2;

    logic pclk = 1'b0, reset_n = 1'b1, config_done = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    always #5 pclk = ~pclk;

    logic [15:0] pd2;
    logic [7:0]  pd1;
    logic        pv2, fs2, fd2, fe2, pv1, fs1, fd1, fe1;
    logic [1:0]  x2, x1;
    logic [0:0]  y2, y1;
    logic [2:0]  a2, a1;

    cam_capture_dvp #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(2)) u_dut2 (
        .pclk(pclk), .reset_n(reset_n), .config_done(config_done), .vsync(vsync), .href(href),
        .cam_data(cam_data), .pixel_data(pd2), .pixel_valid(pv2), .x_coord(x2), .y_coord(y2),
        .wr_addr(a2), .frame_start(fs2), .frame_done(fd2), .frame_err(fe2));

    cam_capture_dvp #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(1)) u_dut1 (
        .pclk(pclk), .reset_n(reset_n), .config_done(config_done), .vsync(vsync), .href(href),
        .cam_data(cam_data), .pixel_data(pd1), .pixel_valid(pv1), .x_coord(x1), .y_coord(y1),
        .wr_addr(a1), .frame_start(fs1), .frame_done(fd1), .frame_err(fe1));

    typedef struct { logic [15:0] d; int x; int y; int a; } pix_t;
    typedef struct { int l0; int l1; int l2; int n; bit tight; bit err; } vec_t;

    pix_t q[$];
    bit   fq[$];
    pix_t e_in, e_out;
    vec_t tab[8];
    int   vectors = 0, miscompares = 0, n_start = 0, exp_start = 0, bpp = 2;
    bit   mon2 = 1'b1, exp_on = 1'b1;
    logic [7:0] b = 8'h12, hi = 8'h00;

    logic [15:0] m_pd;
    logic [31:0] m_x, m_y, m_a;
    logic        m_pv, m_fs, m_fd, m_fe;
    assign m_pd = mon2 ? pd2 : {8'h00, pd1};
    assign m_pv = mon2 ? pv2 : pv1;
    assign m_x  = mon2 ? {30'b0, x2} : {30'b0, x1};
    assign m_y  = mon2 ? {31'b0, y2} : {31'b0, y1};
    assign m_a  = mon2 ? {29'b0, a2} : {29'b0, a1};
    assign m_fs = mon2 ? fs2 : fs1;
    assign m_fd = mon2 ? fd2 : fd1;
    assign m_fe = mon2 ? fe2 : fe1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (m_pv) begin
            if (q.size() == 0) check("unexpected_pixel_queue_depth", q.size(), 1);
            else begin
                e_out = q.pop_front();
                check("pixel_data", {16'h0, m_pd}, {16'h0, e_out.d});
                check("x_coord", m_x, e_out.x);
                check("y_coord", m_y, e_out.y);
                check("wr_addr", m_a, e_out.a);
            end
        end
        if (m_fd) begin
            if (fq.size() == 0) check("unexpected_frame_done_queue_depth", fq.size(), 1);
            else check("frame_err", {31'b0, m_fe}, {31'b0, fq.pop_front()});
        end
        if (m_fs) n_start++;
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic put_byte(input int i, input int line);
        bit emit;
        int px;
        cam_data = b;
        px = (bpp == 2) ? i / 2 : i;
        emit = exp_on && (bpp == 1 || i % 2 == 1) && px < H && line < V;
        if (bpp == 2 && i % 2 == 0) hi = b;
        if (emit) begin
            e_in.d = (bpp == 2) ? {hi, b} : {8'h00, b};
            e_in.x = px;
            e_in.y = line;
            e_in.a = line * H + px;
            q.push_back(e_in);
        end
        b = b + 8'h22;
        tick;
        if (emit) check("pixel_valid_latency", {31'b0, m_pv}, 1);
    endtask

    task automatic drive_line(input int n, input int line);
        href = 1'b1;
        for (int i = 0; i < n; i++) put_byte(i, line);
        href = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        int lens[3];
        lens = '{v.l0, v.l1, v.l2};
        vsync = 1'b0;
        tick;
        tick;
        exp_start++;
        for (int l = 0; l < v.n; l++) begin
            drive_line(lens[l], l);
            if (!(v.tight && l == v.n - 1)) begin
                tick;
                tick;
            end
        end
        fq.push_back(v.err);
        vsync = 1'b1;
        repeat (3) tick;
    endtask

    initial begin
        tab[0] = '{8, 8, 0, 2, 1'b0, 1'b0};
        tab[1] = '{10, 8, 0, 2, 1'b0, 1'b1};
        tab[2] = '{7, 8, 0, 2, 1'b0, 1'b1};
        tab[3] = '{8, 0, 0, 1, 1'b0, 1'b1};
        tab[4] = '{8, 8, 8, 3, 1'b0, 1'b1};
        tab[5] = '{4, 8, 0, 2, 1'b0, 1'b1};
        tab[6] = '{8, 8, 0, 2, 1'b1, 1'b0};
        tab[7] = '{8, 7, 0, 2, 1'b1, 1'b1};

        #2 reset_n = 1'b0;
        repeat (2) tick;
        check("rst_pixel_data", {16'h0, pd2}, 0);
        check("rst_pixel_valid", {31'b0, pv2}, 0);
        check("rst_x", {30'b0, x2}, 0);
        check("rst_y", {31'b0, y2}, 0);
        check("rst_addr", {29'b0, a2}, 0);
        check("rst_frame_start", {31'b0, fs2}, 0);
        check("rst_frame_done", {31'b0, fd2}, 0);
        check("rst_frame_err", {31'b0, fe2}, 0);
        reset_n = 1'b1;
        tick;
        config_done = 1'b1;
        vsync = 1'b1;
        repeat (3) tick;

        for (int i = 0; i < 8; i++) send_frame(tab[i]);

        // config_done drops after two pixels of the first line; nothing more may come out of that frame
        vsync = 1'b0;
        tick;
        tick;
        exp_start++;
        href = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) config_done = 1'b0;
            put_byte(i, (i < 4) ? 0 : V);
        end
        href = 1'b0;
        tick;
        tick;
        vsync = 1'b1;
        repeat (3) tick;
        vsync = 1'b0;
        tick;
        config_done = 1'b1;
        tick;
        tick;
        exp_on = 1'b0;
        drive_line(8, 0);
        tick;
        tick;
        vsync = 1'b1;
        repeat (3) tick;
        exp_on = 1'b1;
        send_frame(tab[0]);
        check("frame_start_count_bpp2", n_start, exp_start);
        check("pixel_queue_left_bpp2", q.size(), 0);
        check("frame_queue_left_bpp2", fq.size(), 0);

        mon2 = 1'b0;
        bpp = 1;
        n_start = 0;
        exp_start = 0;
        send_frame('{4, 4, 0, 2, 1'b0, 1'b0});

        // asynchronous reset while a 1-byte-per-pixel line is streaming
        vsync = 1'b0;
        tick;
        tick;
        exp_start++;
        href = 1'b1;
        put_byte(0, 0);
        put_byte(1, 0);
        exp_on = 1'b0;
        put_byte(2, 0);
        check("pv_before_reset", {31'b0, pv1}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pixel_data", {24'h0, pd1}, 0);
        check("async_rst_pixel_valid", {31'b0, pv1}, 0);
        check("async_rst_x", {30'b0, x1}, 0);
        check("async_rst_y", {31'b0, y1}, 0);
        check("async_rst_addr", {29'b0, a1}, 0);
        check("async_rst_frame_start", {31'b0, fs1}, 0);
        check("async_rst_frame_done", {31'b0, fd1}, 0);
        check("async_rst_frame_err", {31'b0, fe1}, 0);
        href = 1'b0;
        tick;
        check("frame_start_count_bpp1", n_start, exp_start);
        check("pixel_queue_left_bpp1", q.size(), 0);
        check("frame_queue_left_bpp1", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
